vector_fetch_ctrl: RTL and testbench
====================================

VECTOR_FETCH_CTRL -- requirements
Module: vector_fetch_ctrl

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8: element width.
- VECTOR_WIDTH, default 4: elements per vector.
- ADDR_WIDTH, default 5: memory address width.
- MEM_LATENCY, default 1 (legal 1..3): memory read latency in cycles.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; begins a job.
- base_addr1  in  ADDR_WIDTH  vector-A start address, sampled at start.
- base_addr2  in  ADDR_WIDTH  vector-B start address, sampled at start.
- num_vectors  in  ADDR_WIDTH  vector count, sampled at start.
- mem1_en  out  1  memory-1 read enable.
- mem1_addr  out  ADDR_WIDTH  memory-1 read address.
- mem1_rdata  in  DATA_WIDTH  memory-1 read data.
- mem2_en  out  1  memory-2 read enable.
- mem2_addr  out  ADDR_WIDTH  memory-2 read address.
- mem2_rdata  in  DATA_WIDTH  memory-2 read data.
- mem1_input  out  DATA_WIDTH  element A to the dot-product stage.
- mem2_input  out  DATA_WIDTH  element B to the dot-product stage.
- data_valid  out  1  element pair valid.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- vec_count  out  ADDR_WIDTH  vectors fully issued in the current job.

Function
REQ-003 The FSM SHALL have the states IDLE, FETCH, DRAIN and DONE.
REQ-004 In IDLE with start=1, the block SHALL latch base_addr1, base_addr2 and num_vectors, clear vec_count, and go to FETCH; if num_vectors=0 it SHALL go directly to DONE instead.
REQ-005 In FETCH, mem1_en and mem2_en SHALL both be 1 every cycle; each cycle one address pair is issued, and both addresses increment by 1 per element.
REQ-006 Address increment SHALL wrap modulo 2^ADDR_WIDTH.
REQ-007 The element index SHALL count 0..VECTOR_WIDTH-1; on the last element, vec_count increments by 1 and the index returns to 0.
REQ-008 When the last element of vector num_vectors-1 is issued, the FSM SHALL go to DRAIN with mem*_en=0 from the next cycle.
REQ-009 A read issued in cycle t SHALL produce data_valid=1 in cycle t+MEM_LATENCY+1; in that cycle, mem1_input/mem2_input equal mem1_rdata/mem2_rdata registered at t+MEM_LATENCY.
REQ-010 DRAIN SHALL last until the last issued read has produced its data_valid, then go to DONE.
REQ-011 DONE SHALL last one cycle: done=1, busy=0 in that cycle, then go to IDLE.
REQ-012 busy SHALL be 1 in FETCH and DRAIN and 0 otherwise.
REQ-013 start SHALL be ignored while the FSM is not in IDLE.
REQ-014 data_valid SHALL be 1 for exactly num_vectors*VECTOR_WIDTH cycles per job.
REQ-015 The elements of one vector SHALL be delivered on consecutive cycles.
REQ-016 Element pairs SHALL be delivered in address order.
REQ-017 mem1_input/mem2_input SHALL hold their last value while data_valid=0.

Reset
REQ-018 With rst_n=0 at a clock edge, the block SHALL enter IDLE.
REQ-019 The following SHALL reset to 0: mem*_en, mem*_addr, mem*_input, data_valid, busy, done, vec_count, the element index and the latency pipeline.
REQ-020 Reset mid-job SHALL abort the job: no further data_valid and no done pulse.

Configuration
REQ-021 With macro VFC_INTER_VECTOR_GAP_EN defined, FETCH SHALL insert exactly one idle cycle (mem*_en=0) after the last element of every vector except the final one, so data_valid shows a one-cycle gap between vectors.
REQ-022 Without VFC_INTER_VECTOR_GAP_EN, vectors SHALL be issued back to back with no gap.

Verification
REQ-023 The bench SHALL cover these scenarios (macro undefined, MEM_LATENCY=1 unless stated):
- Scenario 1: base 0/16, num_vectors=1 -> addresses 0..3 and 16..19 on cycles 1..4 after start; data_valid on cycles 3..6; done at cycle 7.
- Scenario 2: num_vectors=3 -> 12 consecutive data_valid cycles; vec_count ends at 3.
- Scenario 3: base_addr1=30, num_vectors=1 -> mem1_addr sequence 30, 31, 0, 1.
- Scenario 4: num_vectors=0 -> done pulse the cycle after start; no mem_en and no data_valid.
- Scenario 5: start pulsed again during FETCH, then rst_n=0 for 1 cycle mid-job -> second start ignored; all outputs 0 after reset; no done.
- Scenario 6: VFC_INTER_VECTOR_GAP_EN defined, num_vectors=2, MEM_LATENCY=2 -> data_valid pattern 1111 0 1111; done 1 cycle after the last valid.

Source files
------------

// File: rtl/vector_fetch_ctrl_if.sv
// Memory read bus between vector_fetch_ctrl and its two operand memories.
// master: the fetch controller; slave: the memories returning read data.
interface vector_fetch_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  mem1_en;
  logic [ADDR_WIDTH-1:0] mem1_addr;
  logic [DATA_WIDTH-1:0] mem1_rdata;
  logic                  mem2_en;
  logic [ADDR_WIDTH-1:0] mem2_addr;
  logic [DATA_WIDTH-1:0] mem2_rdata;

  modport master (
    output mem1_en, mem1_addr, mem2_en, mem2_addr,
    input  mem1_rdata, mem2_rdata
  );

  modport slave (
    input  mem1_en, mem1_addr, mem2_en, mem2_addr,
    output mem1_rdata, mem2_rdata
  );
endinterface

// File: rtl/vector_fetch_ctrl.sv
// Fetches paired vector operands from two memories and streams element pairs to a dot-product stage.
// Optional feature: define VFC_INTER_VECTOR_GAP_EN to insert one idle issue cycle between vectors.
module vector_fetch_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int ADDR_WIDTH   = 5,
  parameter int MEM_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr1,
  input  logic [ADDR_WIDTH-1:0] base_addr2,
  input  logic [ADDR_WIDTH-1:0] num_vectors,
  vector_fetch_ctrl_if.master   mem,
  output logic [DATA_WIDTH-1:0] mem1_input,
  output logic [DATA_WIDTH-1:0] mem2_input,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] vec_count
);

  localparam int IDX_W = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  num_vec_q;
  logic [IDX_W-1:0]       elem_idx;
  logic [ADDR_WIDTH-1:0]  vec_nxt;
  logic [MEM_LATENCY-1:0] vld_p;
  logic                   pipe_empty;

  assign vec_nxt    = vec_count + ADDR_WIDTH'(1);
  assign pipe_empty = ~|vld_p;

  // Issue stage: FSM drives the read requests one element pair per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      num_vec_q     <= '0;
      elem_idx      <= '0;
      vec_count     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem.mem1_en   <= 1'b0;
      mem.mem2_en   <= 1'b0;
      mem.mem1_addr <= '0;
      mem.mem2_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_vec_q     <= num_vectors;
            vec_count     <= '0;
            elem_idx      <= '0;
            mem.mem1_addr <= base_addr1;
            mem.mem2_addr <= base_addr2;
            if (num_vectors == '0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state       <= FETCH;
              busy        <= 1'b1;
              mem.mem1_en <= 1'b1;
              mem.mem2_en <= 1'b1;
            end
          end
        end

        FETCH: begin
`ifdef VFC_INTER_VECTOR_GAP_EN
          // A low enable inside FETCH marks the inter-vector idle slot
          if (!mem.mem1_en) begin
            mem.mem1_en <= 1'b1;
            mem.mem2_en <= 1'b1;
          end else
`endif
          begin
            if (elem_idx == LAST_IDX) begin
              elem_idx  <= '0;
              vec_count <= vec_nxt;
              if (vec_nxt == num_vec_q) begin
                state       <= DRAIN;
                mem.mem1_en <= 1'b0;
                mem.mem2_en <= 1'b0;
              end else begin
                mem.mem1_addr <= mem.mem1_addr + ADDR_WIDTH'(1);
                mem.mem2_addr <= mem.mem2_addr + ADDR_WIDTH'(1);
`ifdef VFC_INTER_VECTOR_GAP_EN
                mem.mem1_en   <= 1'b0;
                mem.mem2_en   <= 1'b0;
`endif
              end
            end else begin
              elem_idx      <= elem_idx + IDX_W'(1);
              mem.mem1_addr <= mem.mem1_addr + ADDR_WIDTH'(1);
              mem.mem2_addr <= mem.mem2_addr + ADDR_WIDTH'(1);
            end
          end
        end

        DRAIN: begin
          // Leave once no issued read is still travelling through the latency pipe
          if (pipe_empty) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Latency stage: tracks which cycles carry returned read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= mem.mem1_en;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  // Output stage: capture read data; hold it while no pair is valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_valid <= 1'b0;
      mem1_input <= '0;
      mem2_input <= '0;
    end else begin
      data_valid <= vld_p[MEM_LATENCY-1];
      if (vld_p[MEM_LATENCY-1]) begin
        mem1_input <= mem.mem1_rdata;
        mem2_input <= mem.mem2_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vector_fetch_ctrl.sv
// Self-checking bench for vector_fetch_ctrl: memory model, data scoreboard and per-scenario timing checks.
// With VFC_INTER_VECTOR_GAP_EN defined the bench runs at MEM_LATENCY=2 and adds the gap scenario.
module tb_vector_fetch_ctrl;

  localparam int DW = 8;
  localparam int VW = 4;
  localparam int AW = 5;
`ifdef VFC_INTER_VECTOR_GAP_EN
  localparam int LAT = 2;
  localparam int GAP = 1;
`else
  localparam int LAT = 1;
  localparam int GAP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr1 = '0;
  logic [AW-1:0] base_addr2 = '0;
  logic [AW-1:0] num_vectors = '0;
  logic [DW-1:0] mem1_input, mem2_input;
  logic          data_valid, busy, done;
  logic [AW-1:0] vec_count;

  int checks = 0;
  int failures = 0;
  int dv_seen = 0;

  logic [DW-1:0]   m1 [32];
  logic [DW-1:0]   m2 [32];
  logic [DW-1:0]   rp1 [LAT];
  logic [DW-1:0]   rp2 [LAT];
  logic [2*DW-1:0] sb [$];

  vector_fetch_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem ();

  vector_fetch_ctrl #(
    .DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr1(base_addr1), .base_addr2(base_addr2), .num_vectors(num_vectors),
    .mem(mem),
    .mem1_input(mem1_input), .mem2_input(mem2_input),
    .data_valid(data_valid), .busy(busy), .done(done), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  // Memories with LAT-cycle read latency; garbage on the bus when not enabled
  always @(posedge clk) begin
    rp1[0] <= mem.mem1_en ? m1[mem.mem1_addr] : DW'($urandom);
    rp2[0] <= mem.mem2_en ? m2[mem.mem2_addr] : DW'($urandom);
    for (int k = 1; k < LAT; k++) begin
      rp1[k] <= rp1[k-1];
      rp2[k] <= rp2[k-1];
    end
  end
  assign mem.mem1_rdata = rp1[LAT-1];
  assign mem.mem2_rdata = rp2[LAT-1];

  // Scoreboard: every valid pair must match the next expected pair in address order
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_seen++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_valid got a=%0h b=%0h expected no valid", mem1_input, mem2_input);
      end else begin
        logic [2*DW-1:0] e;
        e = sb.pop_front();
        if ({mem1_input, mem2_input} !== e)
          begin
            failures++;
            $display("FAIL sb_pair got a=%0h b=%0h expected a=%0h b=%0h",
                     mem1_input, mem2_input, e[2*DW-1:DW], e[DW-1:0]);
          end
      end
    end
  end

  function automatic bit is_issue(int c, int n);
    int k;
    if (c < 1) return 1'b0;
    k = c - 1;
    return ((k / (VW + GAP)) < n) && ((k % (VW + GAP)) < VW);
  endfunction

  function automatic int elem_of(int c);
    int k;
    k = c - 1;
    return (k / (VW + GAP)) * VW + (k % (VW + GAP));
  endfunction

  function automatic int done_cycle(int n);
    return 1 + (n - 1) * (VW + GAP) + (VW - 1) + LAT + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle and queues the expected element pairs; returns in cycle 1
  task automatic start_job(input int a1, input int a2, input int n);
    base_addr1  = AW'(a1);
    base_addr2  = AW'(a2);
    num_vectors = AW'(n);
    start = 1'b1;
    for (int i = 0; i < n * VW; i++)
      sb.push_back({m1[AW'(a1 + i)], m2[AW'(a2 + i)]});
    dv_seen = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({mem.mem1_en, mem.mem2_en, mem.mem1_addr, mem.mem2_addr} !== '0) begin
      failures++;
      $display("FAIL reset_mem got en=%b%b a1=%0d a2=%0d expected 0", mem.mem1_en, mem.mem2_en,
               mem.mem1_addr, mem.mem2_addr);
    end
    checks++;
    if ({mem1_input, mem2_input, data_valid, busy, done, vec_count} !== '0) begin
      failures++;
      $display("FAIL reset_out got in=%0h/%0h dv=%b busy=%b done=%b vc=%0d expected 0",
               mem1_input, mem2_input, data_valid, busy, done, vec_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int dc;
    bit e;
    dc = done_cycle(1);
    start_job(0, 16, 1);
    for (int c = 1; c <= dc + 3; c++) begin
      e = is_issue(c, 1);
      checks++;
      if ({mem.mem1_en, mem.mem2_en} !== {e, e}) begin
        failures++;
        $display("FAIL single_en c=%0d got %b%b expected %b", c, mem.mem1_en, mem.mem2_en, e);
      end
      if (e) begin
        checks++;
        if ({mem.mem1_addr, mem.mem2_addr} !== {AW'(elem_of(c)), AW'(16 + elem_of(c))}) begin
          failures++;
          $display("FAIL single_addr c=%0d got %0d/%0d expected %0d/%0d", c, mem.mem1_addr,
                   mem.mem2_addr, elem_of(c), 16 + elem_of(c));
        end
      end
      checks++;
      if (data_valid !== is_issue(c - LAT - 1, 1)) begin
        failures++;
        $display("FAIL single_dv c=%0d got %b expected %b", c, data_valid, is_issue(c - LAT - 1, 1));
      end
      checks++;
      if ({done, busy} !== {(c == dc), (c < dc)}) begin
        failures++;
        $display("FAIL single_done_busy c=%0d got %b%b expected %b%b", c, done, busy, (c == dc), (c < dc));
      end
      tick();
    end
    checks++;
    if ({mem1_input, mem2_input} !== {m1[3], m2[19]}) begin
      failures++;
      $display("FAIL single_hold got %0h/%0h expected %0h/%0h", mem1_input, mem2_input, m1[3], m2[19]);
    end
    checks++;
    if (dv_seen != 4) begin
      failures++;
      $display("FAIL single_dv_count got %0d expected 4", dv_seen);
    end
  endtask

  task automatic test_multi();
    int first, last, cnt, dc;
    bit got_done;
    first = -1; last = -1; cnt = 0; dc = -1; got_done = 1'b0;
    start_job(4, 20, 3);
    for (int c = 1; c <= 80 && !got_done; c++) begin
      if (c == VW + 1) begin
        checks++;
        if (vec_count !== AW'(1)) begin
          failures++;
          $display("FAIL multi_vc_mid got %0d expected 1", vec_count);
        end
      end
      if (data_valid === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        dc = c;
        checks++;
        if (vec_count !== AW'(3)) begin
          failures++;
          $display("FAIL multi_vc_end got %0d expected 3", vec_count);
        end
      end
      tick();
    end
    checks++;
    if (!got_done) begin
      failures++;
      $display("FAIL multi_timeout got no done expected done within 80 cycles");
    end
    checks++;
    if (cnt != 12 || (last - first + 1) != 12 + 2 * GAP) begin
      failures++;
      $display("FAIL multi_dv_run got count=%0d span=%0d expected 12/%0d", cnt, last - first + 1, 12 + 2 * GAP);
    end
    checks++;
    if (dc != last + 1) begin
      failures++;
      $display("FAIL multi_done_cycle got %0d expected %0d", dc, last + 1);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] wexp [4];
    int k;
    bit got_done;
    wexp[0] = 5'd30; wexp[1] = 5'd31; wexp[2] = 5'd0; wexp[3] = 5'd1;
    k = 0;
    got_done = 1'b0;
    start_job(30, 2, 1);
    for (int c = 1; c <= 20 && !got_done; c++) begin
      if (mem.mem1_en === 1'b1) begin
        if (k < 4) begin
          checks++;
          if (mem.mem1_addr !== wexp[k]) begin
            failures++;
            $display("FAIL wrap_addr idx=%0d got %0d expected %0d", k, mem.mem1_addr, wexp[k]);
          end
        end
        k++;
      end
      if (done === 1'b1) got_done = 1'b1;
      tick();
    end
    checks++;
    if (k != 4 || !got_done) begin
      failures++;
      $display("FAIL wrap_issue got issues=%0d done=%b expected 4/1", k, got_done);
    end
    tick();
  endtask

  task automatic test_zero();
    int bad;
    bad = 0;
    start_job(5, 5, 0);
    checks++;
    if ({done, busy, mem.mem1_en, mem.mem2_en} !== 4'b1000) begin
      failures++;
      $display("FAIL zero_done got done=%b busy=%b en=%b%b expected 1/0/00", done, busy,
               mem.mem1_en, mem.mem2_en);
    end
    for (int c = 2; c <= 9; c++) begin
      tick();
      if (mem.mem1_en !== 1'b0 || mem.mem2_en !== 1'b0 || data_valid !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || dv_seen != 0) begin
      failures++;
      $display("FAIL zero_quiet got bad=%0d dv=%0d expected 0/0", bad, dv_seen);
    end
  endtask

  task automatic test_abort();
    int bad;
    bad = 0;
    start_job(8, 24, 2);
    tick();
    base_addr1 = '0; base_addr2 = '0; num_vectors = AW'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({mem.mem1_en, busy, mem.mem1_addr, mem.mem2_addr} !== {1'b1, 1'b1, 5'd10, 5'd26}) begin
      failures++;
      $display("FAIL abort_restart got en=%b busy=%b a=%0d/%0d expected 1/1/10/26", mem.mem1_en,
               busy, mem.mem1_addr, mem.mem2_addr);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({mem.mem1_en, mem.mem2_en, mem.mem1_addr, mem.mem2_addr, mem1_input, mem2_input,
         data_valid, busy, done, vec_count} !== '0) begin
      failures++;
      $display("FAIL abort_reset got en=%b%b a=%0d/%0d in=%0h/%0h dv=%b busy=%b done=%b vc=%0d expected 0",
               mem.mem1_en, mem.mem2_en, mem.mem1_addr, mem.mem2_addr, mem1_input, mem2_input,
               data_valid, busy, done, vec_count);
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      if (data_valid !== 1'b0 || done !== 1'b0 || mem.mem1_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_quiet got %0d active cycles expected 0", bad);
    end
    sb.delete();
  endtask

`ifdef VFC_INTER_VECTOR_GAP_EN
  task automatic test_gap();
    int dc;
    dc = done_cycle(2);
    start_job(10, 0, 2);
    for (int c = 1; c <= dc + 2; c++) begin
      checks++;
      if (data_valid !== is_issue(c - LAT - 1, 2)) begin
        failures++;
        $display("FAIL gap_dv c=%0d got %b expected %b", c, data_valid, is_issue(c - LAT - 1, 2));
      end
      checks++;
      if ({done, mem.mem1_en} !== {(c == dc), is_issue(c, 2)}) begin
        failures++;
        $display("FAIL gap_done_en c=%0d got %b%b expected %b%b", c, done, mem.mem1_en,
                 (c == dc), is_issue(c, 2));
      end
      tick();
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) begin
      m1[i] = DW'(i * 7 + 3);
      m2[i] = DW'(32'hC0 ^ (i * 5));
    end
    test_reset();
    test_single();
    test_multi();
    test_wrap();
    test_zero();
    test_abort();
`ifdef VFC_INTER_VECTOR_GAP_EN
    test_gap();
`endif
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d pending pairs expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule
